// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall controller for the five-stage MIPS core.
// Merges load-use, multi-cycle EX and MEM-wait stall causes into a per-stage
// hold vector. It also registers the active cause, runs a per-cause watchdog
// and keeps a saturating count of stalled cycles for debug.
//
// MEM handshake: mem_req_i high means an access is outstanding. The access
// completes in the cycle where mem_ack_i is also high. Only req without ack
// stalls, so req & ack together is a zero-wait access.
module hazard_ctrl #(
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg1_read_i,
    input  logic [4:0]       id_reg1_addr_i,
    input  logic             id_reg2_read_i,
    input  logic [4:0]       id_reg2_addr_i,
    input  logic             ex_is_load_i,
    input  logic             ex_wreg_i,
    input  logic [4:0]       ex_wd_i,
    input  logic             ex_busy_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             cnt_clr_i,
    output logic [5:0]       stall_o,
    output logic [1:0]       state_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_USE  = 2'd1,
        ST_EX_WAIT   = 2'd2,
        ST_MEM_WAIT  = 2'd3
    } state_t;

    localparam logic [15:0]      TIMEOUT_LAST = 16'(STALL_TIMEOUT - 1);
    localparam logic [15:0]      WAIT_MAX     = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q;
    state_t           next_state;
    logic             lu;
    logic             mw;
    logic             xw;
    logic [5:0]       stall_raw;
    logic [15:0]      wait_cnt;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    // Raw stall causes. $0 is hardwired to zero, so it never creates a dependency.
    always_comb begin
        lu = ex_is_load_i & ex_wreg_i & (ex_wd_i != 5'd0) &
             ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
              (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));
        mw = mem_req_i & ~mem_ack_i;
        xw = ex_busy_i;
    end

    // Prioritised cause selection (MEM > EX > LOAD_USE) and hold vector per cause.
    always_comb begin
        next_state = ST_RUN;
        stall_raw  = 6'b000000;
        if (mw) begin
            next_state = ST_MEM_WAIT;
            stall_raw  = 6'b011111;
        end else if (xw) begin
            next_state = ST_EX_WAIT;
            stall_raw  = 6'b001111;
        end else if (lu) begin
            next_state = ST_LOAD_USE;
            stall_raw  = 6'b000111;
        end
    end

    // Reset masks the hold vector immediately, without waiting for a clock edge.
    assign stall_o        = rst ? 6'b000000 : stall_raw;
    assign state_o        = state_q;
    assign err_timeout_o  = err_q;
    assign stall_cycles_o = cnt_q;

    // Registered cause. It may jump directly between any two causes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= next_state;
        end
    end

    // Watchdog run-length counter. It restarts at 1 on a new cause and at 0 on RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 16'd0;
        end else if ((next_state == ST_RUN) || (next_state != state_q)) begin
            wait_cnt <= (next_state != ST_RUN) ? 16'd1 : 16'd0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Sticky timeout flag. It does not release the stall, which is left to the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((wait_cnt == TIMEOUT_LAST) && (next_state == state_q) &&
                     (next_state != ST_RUN)) begin
            err_q <= 1'b1;
        end
    end

    // Saturating stalled-cycle counter. The clear input wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if ((stall_raw != 6'b000000) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (STALL_TIMEOUT=8, CNT_W=4).
// Inputs change on the falling edge. stall_o is checked shortly after that.
// Registered outputs are queued as expectations and checked after the next rising edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_reg1_read_i;
    logic [4:0] id_reg1_addr_i;
    logic       id_reg2_read_i;
    logic [4:0] id_reg2_addr_i;
    logic       ex_is_load_i;
    logic       ex_wreg_i;
    logic [4:0] ex_wd_i;
    logic       ex_busy_i;
    logic       mem_req_i;
    logic       mem_ack_i;
    logic       cnt_clr_i;
    logic [5:0] stall_o;
    logic [1:0] state_o;
    logic       err_timeout_o;
    logic [3:0] stall_cycles_o;

    int checks = 0;
    int errors = 0;

    // Expected {state, err, cnt} after the next rising edge.
    logic [6:0] exp_q[$];

    hazard_ctrl #(
        .STALL_TIMEOUT(8),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_reg1_read_i(id_reg1_read_i),
        .id_reg1_addr_i(id_reg1_addr_i),
        .id_reg2_read_i(id_reg2_read_i),
        .id_reg2_addr_i(id_reg2_addr_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_wreg_i     (ex_wreg_i),
        .ex_wd_i       (ex_wd_i),
        .ex_busy_i     (ex_busy_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .cnt_clr_i     (cnt_clr_i),
        .stall_o       (stall_o),
        .state_o       (state_o),
        .err_timeout_o (err_timeout_o),
        .stall_cycles_o(stall_cycles_o)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time limit for the whole run
    initial begin
        #100000;
        $display("FAIL time_limit: run did not finish within 100000 time units");
        $fatal(1, "time limit expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_reg1_read_i = 1'b0;
        id_reg1_addr_i = 5'd0;
        id_reg2_read_i = 1'b0;
        id_reg2_addr_i = 5'd0;
        ex_is_load_i   = 1'b0;
        ex_wreg_i      = 1'b0;
        ex_wd_i        = 5'd0;
        ex_busy_i      = 1'b0;
        mem_req_i      = 1'b0;
        mem_ack_i      = 1'b0;
        cnt_clr_i      = 1'b0;
    endtask

    task automatic set_lu(input logic load, input logic wreg, input logic [4:0] wd,
                          input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
        ex_is_load_i   = load;
        ex_wreg_i      = wreg;
        ex_wd_i        = wd;
        id_reg1_read_i = r1;
        id_reg1_addr_i = a1;
        id_reg2_read_i = r2;
        id_reg2_addr_i = a2;
    endtask

    // Called just after a falling edge with inputs already applied.
    // Checks stall_o now, then checks the registered outputs after the next rising edge.
    task automatic step(input string tag, input logic [5:0] e_stall, input logic [1:0] e_state,
                        input logic e_err, input logic [3:0] e_cnt);
        logic [6:0] e;
        #1;
        check({tag, ".stall"}, 32'(stall_o), 32'(e_stall));
        exp_q.push_back({e_state, e_err, e_cnt});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".state"}, 32'(state_o), 32'(e[6:5]));
        check({tag, ".err"}, 32'(err_timeout_o), 32'(e[4]));
        check({tag, ".cnt"}, 32'(stall_cycles_o), 32'(e[3:0]));
        @(negedge clk);
    endtask

    // Directed stimulus sequence
    initial begin
        idle_inputs();
        rst = 1'b1;
        mem_req_i = 1'b1;  // a MEM-wait cause during reset must not stall
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset.stall", 32'(stall_o), 32'h0);
        check("reset.state", 32'(state_o), 32'h0);
        check("reset.err", 32'(err_timeout_o), 32'h0);
        check("reset.cnt", 32'(stall_cycles_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        step("idle", 6'b000000, 2'd0, 1'b0, 4'd0);

        // Load-use detection
        set_lu(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        step("lu_r1", 6'b000111, 2'd1, 1'b0, 4'd1);
        idle_inputs();
        step("lu_after", 6'b000000, 2'd0, 1'b0, 4'd1);
        set_lu(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        step("lu_r0", 6'b000000, 2'd0, 1'b0, 4'd1);
        set_lu(1'b1, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd7);
        step("lu_r2", 6'b000111, 2'd1, 1'b0, 4'd2);
        set_lu(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9);
        step("lu_both", 6'b000111, 2'd1, 1'b0, 4'd3);
        set_lu(1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9);
        step("lu_nowreg", 6'b000000, 2'd0, 1'b0, 4'd3);
        set_lu(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9);
        step("lu_noload", 6'b000000, 2'd0, 1'b0, 4'd3);
        set_lu(1'b1, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd9);
        step("lu_noread", 6'b000000, 2'd0, 1'b0, 4'd3);

        // Priority: all causes, then drop MEM wait
        set_lu(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        ex_busy_i = 1'b1;
        mem_req_i = 1'b1;
        step("prio_all", 6'b011111, 2'd3, 1'b0, 4'd4);
        mem_req_i = 1'b0;
        step("prio_ex", 6'b001111, 2'd2, 1'b0, 4'd5);
        idle_inputs();
        step("prio_idle", 6'b000000, 2'd0, 1'b0, 4'd5);

        // Zero-wait MEM access
        mem_req_i = 1'b1;
        mem_ack_i = 1'b1;
        step("zero_wait", 6'b000000, 2'd0, 1'b0, 4'd5);
        ex_busy_i = 1'b1;
        step("zero_wait_ex", 6'b001111, 2'd2, 1'b0, 4'd6);

        // MEM handshake: three wait cycles, then ack
        idle_inputs();
        cnt_clr_i = 1'b1;
        step("clr_idle", 6'b000000, 2'd0, 1'b0, 4'd0);
        cnt_clr_i = 1'b0;
        mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("mem_wait", 6'b011111, 2'd3, 1'b0, 4'(i + 1));
        end
        mem_ack_i = 1'b1;
        step("mem_ack", 6'b000000, 2'd0, 1'b0, 4'd3);
        idle_inputs();
        step("mem_done", 6'b000000, 2'd0, 1'b0, 4'd3);

        // Watchdog: 7 busy cycles stay below the limit
        ex_busy_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step("wd7", 6'b001111, 2'd2, 1'b0, 4'(4 + i));
        end
        idle_inputs();
        step("wd7_idle", 6'b000000, 2'd0, 1'b0, 4'd10);

        // Watchdog: 10 busy cycles trip it after the 8th. Count saturates at 15
        ex_busy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("wd10", 6'b001111, 2'd2, (i >= 7) ? 1'b1 : 1'b0,
                 (11 + i > 15) ? 4'd15 : 4'(11 + i));
        end
        idle_inputs();
        step("wd10_sticky", 6'b000000, 2'd0, 1'b1, 4'd15);

        // Clear during a stall wins over counting
        ex_busy_i = 1'b1;
        cnt_clr_i = 1'b1;
        step("clr_stall", 6'b001111, 2'd2, 1'b1, 4'd0);
        cnt_clr_i = 1'b0;
        step("after_clr", 6'b001111, 2'd2, 1'b1, 4'd1);

        // Long MEM wait: EX_WAIT goes directly to MEM_WAIT, count saturates at 15
        mem_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("cnt_sat", 6'b011111, 2'd3, 1'b1, (2 + i > 15) ? 4'd15 : 4'(2 + i));
        end

        // Asynchronous reset between edges while in MEM_WAIT
        #1;
        check("pre_rst.stall", 32'(stall_o), 32'h1f);
        check("pre_rst.state", 32'(state_o), 32'h3);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.stall", 32'(stall_o), 32'h0);
        check("async_rst.state", 32'(state_o), 32'h0);
        check("async_rst.err", 32'(err_timeout_o), 32'h0);
        check("async_rst.cnt", 32'(stall_cycles_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        step("post_rst", 6'b000000, 2'd0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
